// File: rtl/rv32i_halt_monitor.sv
// rv32i_halt_monitor: detects the jal-self/nop idle loop of an RV32I core and counts fetches and cycles.
// Optional watchdog (TIMEOUT state, timeout_o) is built only when HALT_MON_WATCHDOG_EN is defined.
module rv32i_halt_monitor #(
   parameter int unsigned LOOP_COUNT = 5,
   parameter logic [31:0] WDT_CYCLES = 32'd1000,
   parameter logic [31:0] HALT_INST  = 32'h0000006F,
   parameter logic [31:0] NOP_INST   = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_i,
   input  logic        clear_i,
   output logic        halt_o,
   output logic        timeout_o,
   output logic [7:0]  loop_cnt_o,
   output logic [31:0] inst_cnt_o,
   output logic [31:0] cycle_cnt_o
);
`ifdef HALT_MON_WATCHDOG_EN
   typedef enum logic [2:0] {IDLE, SEEN_J, SKIP, HALTED, TIMEOUT} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEEN_J, SKIP, HALTED} state_t;
`endif
   state_t      state;
   logic        live, acc, is_j, is_n, hit;
   logic [7:0]  loop_inc;
   logic [31:0] cycle_nxt;
`ifdef HALT_MON_WATCHDOG_EN
   logic        wdt;
   assign live = state != HALTED && state != TIMEOUT;
   // halt detection wins over a watchdog expiry on the same edge
   assign wdt  = live && !hit && cycle_nxt >= WDT_CYCLES;
`else
   assign live = state != HALTED;
`endif
   assign acc       = inst_valid_i && live;
   assign is_j      = inst_i == HALT_INST;
   assign is_n      = inst_i == NOP_INST;
   assign loop_inc  = loop_cnt_o + 8'd1;
   assign hit       = state == SEEN_J && acc && is_n && loop_inc == 8'(LOOP_COUNT);
   assign cycle_nxt = cycle_cnt_o + {31'b0, ~&cycle_cnt_o};
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state       <= IDLE;
         halt_o      <= 1'b0;
         timeout_o   <= 1'b0;
         loop_cnt_o  <= '0;
         inst_cnt_o  <= '0;
         cycle_cnt_o <= '0;
      end else if (clear_i) begin
         state       <= IDLE;
         halt_o      <= 1'b0;
         timeout_o   <= 1'b0;
         loop_cnt_o  <= '0;
         inst_cnt_o  <= '0;
         cycle_cnt_o <= '0;
      end else begin
         cycle_cnt_o <= cycle_nxt;
         if (acc) begin
            inst_cnt_o <= inst_cnt_o + {31'b0, ~&inst_cnt_o};
            case (state)
               IDLE:    if (is_j) state <= SEEN_J;
               SEEN_J:
                  if (is_n) begin
                     loop_cnt_o <= loop_inc;
                     state      <= hit ? HALTED : IDLE;
                     if (hit) halt_o <= 1'b1;
                  end else begin
                     loop_cnt_o <= '0;
                     state      <= SKIP;
                  end
               SKIP:    state <= IDLE;
               default: ;
            endcase
         end
`ifdef HALT_MON_WATCHDOG_EN
         if (wdt) begin
            state     <= TIMEOUT;
            timeout_o <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_rv32i_halt_monitor.sv
// tb_rv32i_halt_monitor: directed checks of the halt monitor; dut_t (WDT 20) and dut_c (WDT 10,
// expiry on the fifth-nop edge) share the stimulus of the main dut.
module tb_rv32i_halt_monitor;
`ifdef HALT_MON_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif
   localparam logic [31:0] J = 32'h0000006F;
   localparam logic [31:0] N = 32'h00000013;
   logic        clk_i = 1'b0, reset_i = 1'b0, inst_valid_i = 1'b0, clear_i = 1'b0;
   logic [31:0] inst_i = '0;
   logic        halt_o, timeout_o, t_halt, t_to, c_halt, c_to;
   logic [7:0]  loop_cnt_o, t_loop, c_loop;
   logic [31:0] inst_cnt_o, cycle_cnt_o, t_inst, t_cyc, c_inst, c_cyc;
   int          n_run = 0, n_fail = 0;
   logic [31:0] seq [9];
   logic [7:0]  seq_loop [9];

   rv32i_halt_monitor dut (
      .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .clear_i(clear_i),
      .halt_o(halt_o), .timeout_o(timeout_o), .loop_cnt_o(loop_cnt_o), .inst_cnt_o(inst_cnt_o),
      .cycle_cnt_o(cycle_cnt_o));
   rv32i_halt_monitor #(.WDT_CYCLES(32'd20)) dut_t (
      .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .clear_i(clear_i),
      .halt_o(t_halt), .timeout_o(t_to), .loop_cnt_o(t_loop), .inst_cnt_o(t_inst), .cycle_cnt_o(t_cyc));
   rv32i_halt_monitor #(.WDT_CYCLES(32'd10)) dut_c (
      .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .clear_i(clear_i),
      .halt_o(c_halt), .timeout_o(c_to), .loop_cnt_o(c_loop), .inst_cnt_o(c_inst), .cycle_cnt_o(c_cyc));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // inputs change at the falling edge; outputs are checked at the next falling edge
   task automatic step(input logic v, input logic [31:0] d);
      inst_valid_i = v;
      inst_i = d;
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      inst_valid_i = 1'b0;
      clear_i = 1'b0;
      #1;
      chk("rst_halt", halt_o, 0);
      chk("rst_to", timeout_o, 0);
      chk("rst_loop", loop_cnt_o, 0);
      chk("rst_inst", inst_cnt_o, 0);
      chk("rst_cyc", cycle_cnt_o, 0);
      #1 reset_i = 1'b0;
   endtask

   initial begin
      seq = '{J, N, J, N, J, 32'h00000033, J, J, N};
      seq_loop = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1};
      @(negedge clk_i);
      // five back-to-back pairs
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, J);
         chk("p_loop_j", loop_cnt_o, i - 1);
         chk("p_halt_j", halt_o, 0);
         step(1'b1, N);
         chk("p_loop_n", loop_cnt_o, i);
         chk("p_halt_n", halt_o, i == 5);
      end
      chk("p_to", timeout_o, 0);
      chk("p_inst", inst_cnt_o, 10);
      chk("p_cyc", cycle_cnt_o, 10);
      chk("c_halt", c_halt, 1);
      chk("c_to", c_to, 0);
      // terminal state freezes loop and inst counts
      step(1'b1, J);
      step(1'b1, N);
      chk("f_loop", loop_cnt_o, 5);
      chk("f_inst", inst_cnt_o, 10);
      chk("f_cyc", cycle_cnt_o, 12);
      chk("f_halt", halt_o, 1);
      // clear while halted
      clear_i = 1'b1;
      step(1'b1, J);
      clear_i = 1'b0;
      chk("clr_halt", halt_o, 0);
      chk("clr_loop", loop_cnt_o, 0);
      chk("clr_inst", inst_cnt_o, 0);
      chk("clr_cyc", cycle_cnt_o, 0);
      step(1'b1, N);
      chk("clr_loop2", loop_cnt_o, 0);
      chk("clr_inst2", inst_cnt_o, 1);
      chk("clr_cyc2", cycle_cnt_o, 1);
      // broken pair then discarded word
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(1'b1, seq[i]);
         chk("s_loop", loop_cnt_o, seq_loop[i]);
      end
      chk("s_halt", halt_o, 0);
      chk("s_inst", inst_cnt_o, 9);
      // pairs with three invalid cycles between words
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, i[0] ? J : N);
         chk("g_loop", loop_cnt_o, i / 2);
         if (i < 10) for (int k = 0; k < 3; k++) step(1'b0, k[0] ? N : J);
         if (i < 10) chk("g_loop_gap", loop_cnt_o, i / 2);
      end
      chk("g_halt", halt_o, 1);
      chk("g_inst", inst_cnt_o, 10);
      chk("g_cyc", cycle_cnt_o, 37);
      // asynchronous reset mid-sequence with loop_cnt = 3 and the FSM in SEEN_J
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, J);
         step(1'b1, N);
      end
      step(1'b1, J);
      chk("a_loop_pre", loop_cnt_o, 3);
      inst_valid_i = 1'b0;
      #2 reset_i = 1'b1;
      #1;
      chk("a_loop", loop_cnt_o, 0);
      chk("a_inst", inst_cnt_o, 0);
      chk("a_cyc", cycle_cnt_o, 0);
      chk("a_halt", halt_o, 0);
      #1 reset_i = 1'b0;
      step(1'b1, N);
      chk("a_loop2", loop_cnt_o, 0);
      chk("a_inst2", inst_cnt_o, 1);
      chk("a_cyc2", cycle_cnt_o, 1);
      // watchdog with no valid words, then a pair sequence
      do_reset();
      for (int i = 1; i <= 25; i++) begin
         step(1'b0, 32'h0);
         chk("w_to", t_to, WD && i >= 20);
         chk("w_cyc", t_cyc, i);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, J);
         step(1'b1, N);
      end
      chk("w_halt", t_halt, WD ? 0 : 1);
      chk("w_loop", t_loop, WD ? 0 : 5);
      chk("w_inst", t_inst, WD ? 0 : 10);
      chk("w_to2", t_to, WD);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
